// File: rtl/moore_edge_pkg.sv
// Shared state encoding and group decode for the Moore edge detector.
// The state names and their 3-bit values are fixed; the channel FSM and the top both depend on them.
package moore_edge_pkg;

    typedef enum logic [2:0] {
        ST_LO   = 3'd0,
        PEND_HI = 3'd1,
        RISE    = 3'd2,
        ST_HI   = 3'd3,
        PEND_LO = 3'd4,
        FALL    = 3'd5
    } edge_state_e;

    // Encodings outside the enum fall to 0, so a corrupted state never reports level=1.
    function automatic logic is_high_group(edge_state_e s);
        return (s == ST_HI) || (s == PEND_LO) || (s == RISE);
    endfunction

endpackage

// File: rtl/moore_edge_channel.sv
// One channel: a Moore FSM with an optional glitch-filter counter.
// The counter and the PEND_* states exist only when MOORE_EDGE_FILTER_EN is defined.
import moore_edge_pkg::*;

module moore_edge_channel #(
    parameter int   FILTER_LEN = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise,
    output logic fall,
    output logic level
);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("moore_edge_channel: FILTER_LEN must be at least 1");
    end

    localparam edge_state_e RST_STATE = INIT_LEVEL ? ST_HI : ST_LO;

    edge_state_e state_reg;

`ifdef MOORE_EDGE_FILTER_EN
    localparam int            CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] cnt_reg;

    // cnt holds the number of new-level samples already seen; the final one accepts the transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RST_STATE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_LO, PEND_HI, FALL: begin
                    if (!in) begin
                        state_reg <= ST_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == LAST) begin
                        state_reg <= RISE;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= PEND_HI;
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                ST_HI, PEND_LO, RISE: begin
                    if (in) begin
                        state_reg <= ST_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == LAST) begin
                        state_reg <= FALL;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= PEND_LO;
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= RST_STATE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end
`else
    // Unfiltered: every change of level is accepted on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RST_STATE;
        end else begin
            case (state_reg)
                ST_LO, PEND_HI, FALL: state_reg <= in ? RISE : ST_LO;
                ST_HI, PEND_LO, RISE: state_reg <= in ? ST_HI : FALL;
                default:              state_reg <= RST_STATE;
            endcase
        end
    end
`endif

    // Outputs depend on the registered state alone.
    assign rise  = (state_reg == RISE);
    assign fall  = (state_reg == FALL);
    assign level = is_high_group(state_reg);

endmodule

// File: rtl/moore_edge_detector.sv
// Multi-channel Moore edge detector: CHANNELS independent copies of moore_edge_channel.
// Define MOORE_EDGE_FILTER_EN to build in the FILTER_LEN-sample glitch filter.
import moore_edge_pkg::*;

module moore_edge_detector #(
    parameter int   CHANNELS   = 8,
    parameter int   FILTER_LEN = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] level
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            moore_edge_channel #(
                .FILTER_LEN (FILTER_LEN),
                .INIT_LEVEL (INIT_LEVEL)
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .in    (in[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi]),
                .level (level[gi])
            );
        end
    endgenerate

endmodule

// File: doc/moore_edge_detector.md
# moore_edge_detector

Multi-channel, parametrised Moore-type edge detector: the successor to our single-bit rising-edge Moore machine. Each of `CHANNELS` inputs gets an independent state machine that emits registered one-cycle `rise` and `fall` pulses and a debounced `level`. An optional glitch filter only accepts a transition after `FILTER_LEN` consecutive samples at the new level. All outputs decode from state only, with no combinational path from `in` to any output. It sits directly behind synchronised external inputs (buttons, strobes, status lines) and feeds event logic.

## Interface
- `CHANNELS`, default 8: number of independent channels, ≥1.
- `FILTER_LEN`, default 4: consecutive samples required to accept a transition, ≥1. Used only with the filter macro defined.
- `INIT_LEVEL`, default 1'b0: stable level every channel takes at reset.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in`, input, CHANNELS: per-channel input, already synchronised to `clk`.
- `rise`, output, CHANNELS: one-cycle pulse on an accepted 0→1 transition.
- `fall`, output, CHANNELS: one-cycle pulse on an accepted 1→0 transition.
- `level`, output, CHANNELS: filtered (accepted) level.

## Operation
- Per-channel states:
  - Low group: ST_LO, PEND_HI, FALL. `level` = 0.
  - High group: ST_HI, PEND_LO, RISE. `level` = 1.
- Output decode:
  - `rise` = (state == RISE).
  - `fall` = (state == FALL).
  - `level` = high group.
- Each channel has a counter `cnt` of width $clog2(FILTER_LEN+1).
- Low-group transitions:
  - `in`=0 → ST_LO, `cnt`=0.
  - `in`=1 and `cnt`+1 == FILTER_LEN → RISE, `cnt`=0.
  - Otherwise `in`=1 → PEND_HI, `cnt`+1.
- High-group transitions mirror the low group:
  - `in`=1 → ST_HI, `cnt`=0.
  - `in`=0 and count reached → FALL.
  - Otherwise `in`=0 → PEND_LO.
- Glitch rejection: if `in` reverts during PEND_*, the channel returns to the stable state, `cnt` clears, and no pulse is emitted.
- RISE/FALL last exactly one cycle unless the opposite transition is accepted immediately.
  - FILTER_LEN=1: RISE with `in`=0 → FALL directly, and FALL with `in`=1 → RISE directly. A 1-cycle input glitch therefore gives `rise` then `fall` on consecutive cycles.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Unreachable state encodings: next state forced to the reset state, outputs 0. No X propagation.

## Timing
- Reset:
  - Every channel goes to ST_LO (INIT_LEVEL=0) or ST_HI (INIT_LEVEL=1), with `cnt`=0.
  - `rise`=`fall`=0 and `level`=INIT_LEVEL from the cycle after the reset edge.
  - Reset mid-filter or mid-pulse aborts it with no pulse.
  - Leaving reset with `in` ≠ INIT_LEVEL is treated as an ordinary transition and filtered normally.
- Latency: the first new-level sample is taken at edge k.
  - Accepted at edge k+FILTER_LEN-1.
  - Pulse is high between edges k+FILTER_LEN-1 and k+FILTER_LEN.
  - `level` changes at the same edge as the pulse.
- FILTER_LEN=1 or filter compiled out: pulse and `level` are valid one edge after sampling, matching the legacy single-bit block's timing.
- Throughput: with FILTER_LEN=1, one accepted transition per channel per cycle.

## Configuration
- `MOORE_EDGE_FILTER_EN` defined:
  - Filter present as described.
  - `cnt` registers and PEND_* states implemented.
- Not defined:
  - FILTER_LEN ignored and behaves as 1.
  - No counters synthesised; PEND_* are never entered.
  - Every input change is accepted on the next edge.
- Port list is identical in both builds.

## Structure
- Package `moore_edge_pkg` holds:
  - `edge_state_e` enum: ST_LO, PEND_HI, RISE, ST_HI, PEND_LO, FALL with fixed 3-bit encoding.
  - Helper function `is_high_group(edge_state_e)`.
- Sub-module `moore_edge_channel`: one FSM plus counter, parameterised by FILTER_LEN and INIT_LEVEL.
- The top instantiates CHANNELS copies in a generate loop.

## Test plan
- Filter off, CHANNELS=1, `in` 0→1 held 3 cycles then 0: `rise` high exactly 1 cycle, one edge after the first 1 sample. `level` 1 for 3 cycles. `fall` pulses one edge after the first 0 sample.
- Filter on, FILTER_LEN=4: `in`=1 for 3 cycles then 0 → no `rise`, `level` stays 0. `in`=1 for 4 cycles → `rise` at the 4th sampling edge.
- FILTER_LEN=1, single-cycle `in` glitch 0-1-0 → `rise` then `fall` on consecutive cycles, `level` 1 for one cycle.
- CHANNELS=8, `in`=8'hA5 from 8'h00 in one cycle → `rise`=8'hA5 for one cycle, `fall`=0. Then `in`=8'h00 → `fall`=8'hA5.
- INIT_LEVEL=1, release reset with `in`=0 for FILTER_LEN cycles → `fall` pulse, `level` goes to 0, no `rise`.
- Assert `rst` in the middle of PEND_HI (filter on) → no pulse. `level`=INIT_LEVEL the next cycle; `cnt` restarts from 0 after release.
